hash_stream_driver: RTL and testbench



---
 rtl/hash_stream_driver_if.sv | 33 +++
 rtl/hash_stream_driver.sv | 220 ++++++++++++++++++++++
 tb/tb_hash_stream_driver.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hash_stream_driver_if.sv
// Bundle of upstream byte stream, hash-core byte/digest lanes and status
// signals used by hash_stream_driver. The master modport is the driver side;
// the slave modport is the host/hash-core environment side.
interface hash_stream_driver_if #(
    parameter int DIGEST_BYTES = 4
);
    logic [7:0]                s_data;
    logic                      s_valid;
    logic                      s_last;
    logic                      s_ready;
    logic [7:0]                hs_data;
    logic                      hs_valid;
    logic                      hs_last;
    logic                      hs_ready;
    logic [7:0]                dg_byte;
    logic                      dg_valid;
    logic [8*DIGEST_BYTES-1:0] digest;
    logic                      digest_valid;
    logic                      busy;
    logic                      err_timeout;

    modport master (
        input  s_data, s_valid, s_last, hs_ready, dg_byte, dg_valid,
        output s_ready, hs_data, hs_valid, hs_last,
               digest, digest_valid, busy, err_timeout
    );

    modport slave (
        output s_data, s_valid, s_last, hs_ready, dg_byte, dg_valid,
        input  s_ready, hs_data, hs_valid, hs_last,
               digest, digest_valid, busy, err_timeout
    );
endinterface

// File: rtl/hash_stream_driver.sv
// hash_stream_driver: buffers upstream message bytes in a small FIFO, streams
// them to the hash core with valid/last framing, then collects the serialized
// digest (MSB first) and presents it as one word. One message in flight.
// Optional macro HASH_STREAM_DRIVER_LEN_COUNT_EN adds the msg_len output.
// All outputs are registered; their next values are derived from next state.
module hash_stream_driver #(
    parameter int DIGEST_BYTES   = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hash_stream_driver_if.master bus
`ifdef HASH_STREAM_DRIVER_LEN_COUNT_EN
    ,
    output logic [15:0]          msg_len
`endif
);
    localparam int DW = 8 * DIGEST_BYTES;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(DIGEST_BYTES) + 1;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_STREAM      = 2'd1,
        ST_WAIT_DIGEST = 2'd2,
        ST_COLLECT     = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [8:0]      mem_r [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_r, wr_ptr_s, rd_ptr_r, rd_ptr_s;
    logic [CW-1:0]   count_r, count_s;
    logic            last_acc_r, last_acc_s;
    logic [7:0]      timer_r, timer_s;
    logic [BW-1:0]   byte_cnt_r, byte_cnt_s;
    logic [DW-1:0]   shadow_r, shadow_s, shifted_s, digest_r;
    logic            push_s, pop_s, done_s, timeout_s;
    logic [8:0]      head_s;
    logic            s_ready_r, s_ready_s;
    logic            hs_valid_r, hs_valid_s, hs_last_r, hs_last_s;
    logic [7:0]      hs_data_r, hs_data_s;
    logic            digest_valid_r, busy_r, err_timeout_r;

    // Next-state logic for the FSM, digest collection and timeout timer
    always_comb begin
        push_s     = bus.s_valid && s_ready_r;
        pop_s      = hs_valid_r && bus.hs_ready;
        state_s    = state_r;
        shadow_s   = shadow_r;
        byte_cnt_s = byte_cnt_r;
        timer_s    = timer_r;
        done_s     = 1'b0;
        timeout_s  = 1'b0;
        shifted_s  = (shadow_r << 8) | DW'(bus.dg_byte);
        case (state_r)
            ST_IDLE: begin
                if (push_s) begin
                    state_s = ST_STREAM;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_STREAM: begin
                // dg_valid is deliberately ignored here
                if (pop_s && hs_last_r) begin
                    state_s = ST_WAIT_DIGEST;
                end else begin
                    state_s = ST_STREAM;
                end
            end
            ST_WAIT_DIGEST, ST_COLLECT: begin
                if (bus.dg_valid) begin
                    shadow_s = shifted_s;
                    timer_s  = 8'd0;
                    if (byte_cnt_r == BW'(DIGEST_BYTES - 1)) begin
                        done_s  = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        byte_cnt_s = byte_cnt_r + BW'(1);
                        state_s    = ST_COLLECT;
                    end
                end else if (timer_r == 8'(TIMEOUT_CYCLES - 1)) begin
                    timeout_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    timer_s = timer_r + 8'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        // Counters restart whenever the FSM heads back to IDLE
        if (state_s == ST_IDLE) begin
            timer_s    = 8'd0;
            byte_cnt_s = '0;
        end else begin
            timer_s    = timer_s;
            byte_cnt_s = byte_cnt_s;
        end
    end

    // FIFO pointer/occupancy update and next values of the registered outputs
    always_comb begin
        wr_ptr_s = push_s ? (wr_ptr_r + PW'(1)) : wr_ptr_r;
        rd_ptr_s = pop_s ? (rd_ptr_r + PW'(1)) : rd_ptr_r;
        count_s  = count_r + CW'(push_s) - CW'(pop_s);
        // A byte written this cycle into the slot that becomes the head
        // must bypass the memory so the head is valid next cycle.
        if (push_s && (rd_ptr_s == wr_ptr_r)) begin
            head_s = {bus.s_last, bus.s_data};
        end else begin
            head_s = mem_r[rd_ptr_s];
        end
        if (state_s == ST_IDLE) begin
            last_acc_s = 1'b0;
        end else if (push_s && bus.s_last) begin
            last_acc_s = 1'b1;
        end else begin
            last_acc_s = last_acc_r;
        end
        s_ready_s  = ((state_s == ST_IDLE) || (state_s == ST_STREAM)) &&
                     (count_s != CW'(FIFO_DEPTH)) && !last_acc_s;
        hs_valid_s = (state_s == ST_STREAM) && (count_s != '0);
        // Head data only moves when a new valid byte is presented
        if (hs_valid_s) begin
            hs_data_s = head_s[7:0];
            hs_last_s = head_s[8];
        end else begin
            hs_data_s = hs_data_r;
            hs_last_s = 1'b0;
        end
    end

    // FIFO storage write; contents need no reset since pointers qualify them
    always_ff @(posedge clk) begin
        if (rst_n && push_s) begin
            mem_r[wr_ptr_r] <= {bus.s_last, bus.s_data};
        end
    end

    // State, counters and registered outputs with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            count_r        <= '0;
            last_acc_r     <= 1'b0;
            timer_r        <= 8'd0;
            byte_cnt_r     <= '0;
            shadow_r       <= '0;
            digest_r       <= '0;
            s_ready_r      <= 1'b0;
            hs_valid_r     <= 1'b0;
            hs_last_r      <= 1'b0;
            hs_data_r      <= 8'd0;
            digest_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            err_timeout_r  <= 1'b0;
        end else begin
            state_r        <= state_s;
            wr_ptr_r       <= wr_ptr_s;
            rd_ptr_r       <= rd_ptr_s;
            count_r        <= count_s;
            last_acc_r     <= last_acc_s;
            timer_r        <= timer_s;
            byte_cnt_r     <= byte_cnt_s;
            shadow_r       <= shadow_s;
            digest_r       <= done_s ? shadow_s : digest_r;
            s_ready_r      <= s_ready_s;
            hs_valid_r     <= hs_valid_s;
            hs_last_r      <= hs_last_s;
            hs_data_r      <= hs_data_s;
            digest_valid_r <= done_s;
            busy_r         <= (state_s != ST_IDLE);
            err_timeout_r  <= timeout_s;
        end
    end

    assign bus.s_ready      = s_ready_r;
    assign bus.hs_valid     = hs_valid_r;
    assign bus.hs_last      = hs_last_r;
    assign bus.hs_data      = hs_data_r;
    assign bus.digest       = digest_r;
    assign bus.digest_valid = digest_valid_r;
    assign bus.busy         = busy_r;
    assign bus.err_timeout  = err_timeout_r;

`ifdef HASH_STREAM_DRIVER_LEN_COUNT_EN
    logic [15:0] len_cnt_r, len_cnt_s, msg_len_r;

    // Saturating count of bytes handed to the hash core in this message
    always_comb begin
        len_cnt_s = len_cnt_r;
        if (state_s == ST_IDLE) begin
            len_cnt_s = 16'h0000;
        end else if (pop_s && (len_cnt_r != 16'hFFFF)) begin
            len_cnt_s = len_cnt_r + 16'h0001;
        end else begin
            len_cnt_s = len_cnt_r;
        end
    end

    // Length counter and the length snapshot taken with each digest
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_cnt_r <= 16'h0000;
            msg_len_r <= 16'h0000;
        end else begin
            len_cnt_r <= len_cnt_s;
            msg_len_r <= done_s ? len_cnt_r : msg_len_r;
        end
    end

    assign msg_len = msg_len_r;
`endif
endmodule

// File: tb/tb_hash_stream_driver.sv
// Scoreboard bench for hash_stream_driver: stimulus pushes expected hash-core
// bytes and expected digest/timeout results into queues; a monitor pops and
// compares whenever the DUT presents a byte or a result.
module tb_hash_stream_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_pop_cyc = 0;
    bit   stab_en = 1'b1;

    hash_stream_driver_if bus ();
`ifdef HASH_STREAM_DRIVER_LEN_COUNT_EN
    logic [15:0] msg_len;
`endif

    hash_stream_driver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef HASH_STREAM_DRIVER_LEN_COUNT_EN
        ,
        .msg_len (msg_len)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        to;
        logic [31:0] dg;
        logic [15:0] len;
    } res_t;

    logic [8:0] exp_hs [$];
    res_t       exp_res [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: hash-core byte stream, hold stability and digest/timeout results
    always @(negedge clk) begin : mon
        logic [8:0] e;
        res_t       r;
        static logic       pv = 1'b0, pr = 1'b0, pl = 1'b0;
        static logic [7:0] pd = 8'd0;
        if (stab_en && pv && !pr) begin
            chk("hs_hold", {bus.hs_valid, bus.hs_last, bus.hs_data}, {1'b1, pl, pd});
        end
        pv = bus.hs_valid; pr = bus.hs_ready; pl = bus.hs_last; pd = bus.hs_data;
        if (bus.hs_valid && bus.hs_ready) begin
            if (exp_hs.size() == 0) begin
                checks++; failures++;
                $display("FAIL hs_unexpected: got byte %0h expected none", bus.hs_data);
            end else begin
                e = exp_hs.pop_front();
                chk("hs_byte", {55'd0, bus.hs_last, bus.hs_data}, {55'd0, e});
            end
            if (bus.hs_last) last_pop_cyc = cyc;
        end
        if (bus.digest_valid || bus.err_timeout) begin
            if (exp_res.size() == 0) begin
                checks++; failures++;
                $display("FAIL res_unexpected: got dv=%0b to=%0b expected none",
                         bus.digest_valid, bus.err_timeout);
            end else begin
                r = exp_res.pop_front();
                chk("res_kind", {62'd0, bus.err_timeout, bus.digest_valid}, {62'd0, r.to, ~r.to});
                chk("res_digest", {32'd0, bus.digest}, {32'd0, r.dg});
`ifdef HASH_STREAM_DRIVER_LEN_COUNT_EN
                if (!r.to) chk("msg_len", {48'd0, msg_len}, {48'd0, r.len});
`endif
            end
        end
    end

    // Offer one upstream byte and hold it until accepted (call at posedge+1)
    task automatic push_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        exp_hs.push_back({l, d});
        bus.s_data = d; bus.s_last = l; bus.s_valid = 1'b1;
        @(negedge clk);
        while (!bus.s_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!bus.s_ready) begin
            checks++; failures++;
            $display("FAIL push_timeout: s_ready stuck 0 for byte %0h expected 1", d);
        end
        step();
        bus.s_valid = 1'b0; bus.s_last = 1'b0;
    endtask

    // Wait for the final byte to leave, then return just after that edge
    task automatic wait_last_pop();
        int n;
        n = 0;
        @(negedge clk);
        while (!(bus.hs_valid && bus.hs_ready && bus.hs_last) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(bus.hs_valid && bus.hs_ready && bus.hs_last)) begin
            checks++; failures++;
            $display("FAIL last_pop_timeout: hs_last never popped expected pop");
        end
        step();
    endtask

    // Return digest bytes MSB first, gap[i] idle cycles before byte i
    task automatic send_dg(input logic [31:0] d, input int g0, input int g1, input int g2, input int g3);
        int gaps [4];
        gaps = '{g0, g1, g2, g3};
        for (int i = 0; i < 4; i++) begin
            repeat (gaps[i]) step();
            bus.dg_valid = 1'b1;
            bus.dg_byte  = d[31 - 8*i -: 8];
            step();
            bus.dg_valid = 1'b0;
            bus.dg_byte  = 8'd0;
        end
    endtask

    // Wait (at negedges) until a digest or timeout is presented
    task automatic wait_result(input int bound);
        int n;
        n = 0;
        @(negedge clk);
        while (!(bus.digest_valid || bus.err_timeout) && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (!(bus.digest_valid || bus.err_timeout)) begin
            checks++; failures++;
            $display("FAIL result_timeout: no digest_valid/err_timeout expected one");
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_data = 8'd0; bus.s_valid = 1'b0; bus.s_last = 1'b0;
        bus.hs_ready = 1'b0; bus.dg_byte = 8'd0; bus.dg_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {bus.s_ready, bus.hs_valid, bus.hs_last, bus.hs_data,
                            bus.digest_valid, bus.busy, bus.err_timeout}, 64'd0);
        chk("rst_digest", {32'd0, bus.digest}, 64'd0);
        step();
        rst_n = 1'b1;

        // 1: basic three-byte message, back-to-back digest bytes
        bus.hs_ready = 1'b1;
        push_byte(8'h61, 1'b0);
        push_byte(8'h62, 1'b0);
        push_byte(8'h63, 1'b1);
        wait_last_pop();
        exp_res.push_back('{to: 1'b0, dg: 32'hDEADBEEF, len: 16'd3});
        send_dg(32'hDEADBEEF, 0, 0, 0, 0);
        wait_result(20);
        chk("t1_busy_at_dv", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        chk("t1_dv_pulse", {62'd0, bus.digest_valid, bus.busy}, 64'd0);

        // 2: no digest after hs_last -> timeout 255 cycles after WAIT entry
        step();
        push_byte(8'h70, 1'b1);
        wait_last_pop();
        exp_res.push_back('{to: 1'b1, dg: 32'hDEADBEEF, len: 16'd0});
        wait_result(400);
        chk("t2_to_latency", 64'(cyc - last_pop_cyc), 64'd256);
        chk("t2_idle_ready", {62'd0, bus.busy, bus.s_ready}, 64'd1);
        @(negedge clk);
        chk("t2_to_pulse", {63'd0, bus.err_timeout}, 64'd0);

        // 3: back-pressure, six bytes through a four-entry FIFO
        step();
        bus.hs_ready = 1'b0;
        push_byte(8'h61, 1'b0);
        push_byte(8'h62, 1'b0);
        push_byte(8'h63, 1'b0);
        push_byte(8'h64, 1'b0);
        @(negedge clk);
        chk("t3_full_stall", {bus.s_ready, bus.hs_valid, bus.hs_data}, {1'b0, 1'b1, 8'h61});
        repeat (3) @(negedge clk);
        chk("t3_head_held", {56'd0, bus.hs_data}, 64'h61);
        step();
        fork
            begin
                push_byte(8'h65, 1'b0);
                push_byte(8'h66, 1'b1);
            end
            begin
                repeat (4) step();
                bus.hs_ready = 1'b1;
            end
        join
        wait_last_pop();
        exp_res.push_back('{to: 1'b0, dg: 32'h01020304, len: 16'd6});
        send_dg(32'h01020304, 0, 0, 0, 0);
        wait_result(20);
        step();

        // 4: digest bytes with idle gaps
        push_byte(8'h41, 1'b1);
        wait_last_pop();
        exp_res.push_back('{to: 1'b0, dg: 32'h11223344, len: 16'd1});
        send_dg(32'h11223344, 0, 3, 0, 5);
        wait_result(20);
        step();

        // 5: reset mid-STREAM with two bytes buffered
        bus.hs_ready = 1'b0;
        push_byte(8'h81, 1'b0);
        push_byte(8'h82, 1'b0);
        stab_en = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_hs.delete();
        @(negedge clk);
        chk("t5_rst_outputs", {bus.s_ready, bus.hs_valid, bus.hs_last, bus.hs_data,
                               bus.digest_valid, bus.busy, bus.err_timeout}, 64'd0);
        chk("t5_rst_digest", {32'd0, bus.digest}, 64'd0);
        step();
        stab_en = 1'b1;
        bus.hs_ready = 1'b1;
        push_byte(8'hFF, 1'b1);
        wait_last_pop();
        exp_res.push_back('{to: 1'b0, dg: 32'hCAFEF00D, len: 16'd1});
        send_dg(32'hCAFEF00D, 0, 0, 0, 0);
        wait_result(20);
        step();

        // 6: back-to-back single-byte messages, stray dg_valid during STREAM
        bus.hs_ready = 1'b0;
        push_byte(8'hA1, 1'b1);
        bus.dg_valid = 1'b1; bus.dg_byte = 8'h99;
        step();
        bus.dg_valid = 1'b0; bus.dg_byte = 8'h00;
        bus.hs_ready = 1'b1;
        wait_last_pop();
        exp_res.push_back('{to: 1'b0, dg: 32'hA0A1A2A3, len: 16'd1});
        send_dg(32'hA0A1A2A3, 0, 0, 0, 0);
        wait_result(20);
        chk("t6_ready_after_dv", {63'd0, bus.s_ready}, 64'd1);
        step();
        push_byte(8'hB1, 1'b1);
        wait_last_pop();
        exp_res.push_back('{to: 1'b0, dg: 32'hB0B1B2B3, len: 16'd1});
        send_dg(32'hB0B1B2B3, 0, 0, 0, 0);
        wait_result(20);
        repeat (3) @(negedge clk);

        chk("hs_queue_drained", 64'(exp_hs.size()), 64'd0);
        chk("res_queue_drained", 64'(exp_res.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
